gtfraw_wrapper_syncer_pulse_pacer: RTL
======================================

# gtfraw_wrapper_syncer_pulse_pacer

Event pacer in the clkin domain, placed directly upstream of the single-pulse clock-domain-crossing syncer. It counts single-cycle event strobes and replays them as one-cycle pulses spaced at least a programmable holdoff apart. This keeps every event from being dropped while the downstream req/ack handshake is still in flight. It also reports backlog and overflow to clkin-domain status logic.

## Interface
Parameters:
- CNT_W, 8, width of the pending-event counter; saturates at 2^CNT_W-1
- HOLD_W, 8, width of holdoff_cycles and the internal holdoff counter
- MIN_HOLDOFF, 2, lower clamp on the effective holdoff; must be ≥1 and < 2^HOLD_W

Ports:
- clkin  in  1  block clock
- clkout_reset_in_sync  in  1  reset, asynchronous, active-low (clkout reset already synchronized into clkin)
- event_in  in  1  event strobe; each high cycle is one event
- holdoff_cycles  in  HOLD_W  requested low-time between output pulses; sampled at pulse issue
- clear  in  1  synchronous clear of backlog and overflow
- pulse_out  out  1  registered one-cycle pulse to the syncer's pulsein
- pending_cnt  out  CNT_W  events accepted but not yet issued
- overflow  out  1  sticky; an event was lost to saturation
- busy  out  1  state != IDLE or pending_cnt != 0

## Operation
- Reset (clkout_reset_in_sync low): state=IDLE, pulse_out=0, pending_cnt=0, overflow=0, holdoff counter=0, busy=0. All outputs are registered.
- Effective holdoff H = max(holdoff_cycles, MIN_HOLDOFF), captured when a pulse issues. Later changes to holdoff_cycles do not affect the running holdoff.
- FSM states:
  - IDLE: if pending_cnt != 0, assert pulse_out for the next cycle, decrement pending, load the hold counter with H, and go to HOLD.
  - HOLD: pulse_out=0. Decrement the hold counter each cycle. When the counter is 1, return to IDLE on that edge.
- Pending counter update per edge, in priority order:
  - clear: pending=0 and overflow=0. A concurrent event_in is discarded. A concurrent issue decision still produces its pulse.
  - Increment and decrement in the same cycle: pending is unchanged.
  - Increment only, at saturation: pending holds and overflow is set.
  - Decrement only happens in IDLE with pending != 0, so there is no underflow.
- clear does not affect the FSM. A running HOLD completes normally.
- pulse_out is never high on two consecutive cycles. This guarantees a rising edge per pulse downstream.

## Timing
- Latency: event_in high at edge N (IDLE, pending 0) gives pending=1 after edge N+1 and pulse_out=1 after edge N+2.
- Spacing: successive pulse_out assertions are exactly H+1 cycles apart while backlog exists, i.e. H low cycles between pulses.
- Throughput: at most one pulse per H+1 cycles. Sustained event_in faster than this grows pending_cnt until saturation, then sets overflow.
- Holdoff sizing for the integrator: H must cover the downstream handshake round trip, which is 2 syncer stages each way plus the clock-ratio margin.
- Reset assertion mid-HOLD or mid-backlog: immediate asynchronous return to the reset values. Release is synchronous to clkin through the upstream reset syncer.

## Structure
- Shared package/header holds the FSM state encodings (IDLE=1'b0, HOLD=1'b1) and the default MIN_HOLDOFF constant.
- Single flat module, no sub-modules. The pending counter, hold counter and FSM are three always blocks in the block's existing next-state/register style.

## Test plan
- Single event with holdoff_cycles=4: event_in high one cycle at edge N gives pulse_out high for exactly one cycle after edge N+2; pending_cnt returns to 0 and busy drops after HOLD exits.
- Burst of 5 consecutive event_in cycles with holdoff_cycles=3: 5 pulses, each 4 cycles apart; pending_cnt peaks at 4; overflow stays 0.
- holdoff_cycles=0 with MIN_HOLDOFF=2 and 3 events: pulses are 3 cycles apart, never adjacent.
- CNT_W=3 with 9 back-to-back events and no drain (holdoff 200): pending_cnt saturates at 7 and overflow=1; then clear together with event_in gives pending=0, overflow=0, and the event is dropped.
- Assert reset mid-HOLD with pending=3: pulse_out, pending_cnt, overflow and busy all go to 0 immediately; after release with no events, no pulse appears.
- Change holdoff_cycles from 10 to 2 during HOLD: the current spacing stays 11 cycles and the next spacing is 3.

Source files
------------

// File: rtl/gtfraw_wrapper_syncer_pulse_pacer_pkg.sv
// gtfraw_wrapper_syncer_pulse_pacer_pkg: shared FSM encoding and default holdoff clamp
package gtfraw_wrapper_syncer_pulse_pacer_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  localparam int MIN_HOLDOFF_DEF = 2;
endpackage

// File: rtl/gtfraw_wrapper_syncer_pulse_pacer.sv
// gtfraw_wrapper_syncer_pulse_pacer: counts event strobes and replays them as pulses spaced by a holdoff
module gtfraw_wrapper_syncer_pulse_pacer
  import gtfraw_wrapper_syncer_pulse_pacer_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int HOLD_W = 8,
  parameter int MIN_HOLDOFF = MIN_HOLDOFF_DEF
) (
  input  logic              clkin,
  input  logic              clkout_reset_in_sync,
  input  logic              event_in,
  input  logic [HOLD_W-1:0] holdoff_cycles,
  input  logic              clear,
  output logic              pulse_out,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              overflow,
  output logic              busy
);
  localparam logic [HOLD_W-1:0] MIN_H = HOLD_W'(MIN_HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt, h_eff;
  logic [CNT_W-1:0] pend_nxt;
  logic issue, ovf_nxt, busy_nxt, sat_inc;
  always_comb begin
    state_nxt = issue ? HOLD : (state == HOLD && hold_cnt == HOLD_W'(1)) ? IDLE : state;
  end
  always_comb begin
    issue = state == IDLE && pending_cnt != '0;
    busy_nxt = state_nxt != IDLE || pend_nxt != '0;
  end
  // an issue absorbs a same-cycle event, so only a lone event can overflow
  always_comb begin
    h_eff = holdoff_cycles > MIN_H ? holdoff_cycles : MIN_H;
    hold_nxt = issue ? h_eff : state == HOLD ? hold_cnt - HOLD_W'(1) : hold_cnt;
    sat_inc = event_in && !issue && pending_cnt == CNT_MAX;
    pend_nxt = clear ? '0 :
               (event_in && !issue && !sat_inc) ? pending_cnt + CNT_W'(1) :
               (!event_in && issue) ? pending_cnt - CNT_W'(1) : pending_cnt;
    ovf_nxt = !clear && (overflow || sat_inc);
  end
  always_ff @(posedge clkin or negedge clkout_reset_in_sync)
    if (!clkout_reset_in_sync) begin
      pending_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      pending_cnt <= pend_nxt;
      overflow <= ovf_nxt;
    end
  always_ff @(posedge clkin or negedge clkout_reset_in_sync)
    if (!clkout_reset_in_sync) hold_cnt <= '0;
    else hold_cnt <= hold_nxt;
  always_ff @(posedge clkin or negedge clkout_reset_in_sync)
    if (!clkout_reset_in_sync) begin
      state <= IDLE;
      pulse_out <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      pulse_out <= issue;
      busy <= busy_nxt;
    end
endmodule
